// File: rtl/spi_bridge_host_if.sv
// rtl/spi_bridge_host_if.sv - request, payload, response, link and status signals of spi_bridge_host
// master is the host block itself; slave is the requester/bridge side driving it.
interface spi_bridge_host_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_tx_len;
  logic [15:0] req_rx_len;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready;
  logic        link_out_valid;
  logic [7:0]  link_out_data;
  logic        link_out_ready;
  logic        link_in_valid;
  logic [7:0]  link_in_data;
  logic        link_in_ready;
  logic        busy;
  logic        done;
  logic        timeout;

  modport master (
    input  req_valid, req_op, req_tx_len, req_rx_len,
    input  wr_valid, wr_data, rd_ready, link_out_ready, link_in_valid, link_in_data,
    output req_ready, wr_ready, rd_valid, rd_data, link_out_valid, link_out_data,
    output link_in_ready, busy, done, timeout
  );

  modport slave (
    output req_valid, req_op, req_tx_len, req_rx_len,
    output wr_valid, wr_data, rd_ready, link_out_ready, link_in_valid, link_in_data,
    input  req_ready, wr_ready, rd_valid, rd_data, link_out_valid, link_out_data,
    input  link_in_ready, busy, done, timeout
  );
endinterface

// File: rtl/spi_bridge_host.sv
// rtl/spi_bridge_host.sv - sequences op/length header, payload and response bytes over the bridge link
// A watchdog aborts any non-idle state that sees no link handshake for TIMEOUT_CYCLES cycles.
module spi_bridge_host #(
  parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
  input logic              clk,
  input logic              reset,
  spi_bridge_host_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_OP, S_TXL, S_TXH, S_RXL, S_RXH, S_PAYLOAD, S_RESP, S_VER
  } state_e;

  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] tx_len_q, tx_len_d;
  logic [15:0] rx_len_q, rx_len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] wdog_q, wdog_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        out_hs, in_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= 2'd0;
      tx_len_q  <= 16'd0;
      rx_len_q  <= 16'd0;
      cnt_q     <= 16'd0;
      wdog_q    <= 32'd0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tx_len_q  <= tx_len_d;
      rx_len_q  <= rx_len_d;
      cnt_q     <= cnt_d;
      wdog_q    <= wdog_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tx_len_d  = tx_len_q;
    rx_len_d  = rx_len_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    wdog_d    = wdog_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          op_d     = bus.req_op;
          tx_len_d = bus.req_tx_len;
          rx_len_d = bus.req_rx_len;
          if (bus.req_op == 2'd3) done_d = 1'b1;
          else                    state_d = S_OP;
        end
      end
      S_OP: begin
        if (out_hs) begin
          case (op_q)
            2'd0: begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
            2'd1:    state_d = S_TXL;
            default: state_d = S_VER;
          endcase
        end
      end
      S_TXL: if (out_hs) state_d = S_TXH;
      S_TXH: if (out_hs) state_d = S_RXL;
      S_RXL: if (out_hs) state_d = S_RXH;
      S_RXH: begin
        if (out_hs) begin
          if (tx_len_q != 16'd0)      state_d = S_PAYLOAD;
          else if (rx_len_q != 16'd0) state_d = S_RESP;
          else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (out_hs) begin
          if (cnt_q == tx_len_q - 16'd1) begin
            cnt_d = 16'd0;
            if (rx_len_q != 16'd0) state_d = S_RESP;
            else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_RESP: begin
        if (in_hs) begin
          if (cnt_q == rx_len_q - 16'd1) begin
            cnt_d   = 16'd0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_VER: begin
        if (in_hs) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins only on a handshake-free cycle, so it never collides with a done.
    if (state_q == S_IDLE || out_hs || in_hs) begin
      wdog_d = 32'd0;
    end else if (wdog_q == WDOG_LAST) begin
      wdog_d    = 32'd0;
      cnt_d     = 16'd0;
      state_d   = S_IDLE;
      timeout_d = 1'b1;
    end else begin
      wdog_d = wdog_q + 32'd1;
    end
  end

  always_comb begin
    bus.req_ready      = 1'b0;
    bus.wr_ready       = 1'b0;
    bus.rd_valid       = 1'b0;
    bus.rd_data        = 8'd0;
    bus.link_out_valid = 1'b0;
    bus.link_out_data  = 8'd0;
    bus.link_in_ready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready     = !done_q;
        bus.link_in_ready = 1'b1;
      end
      S_OP: begin
        bus.link_out_valid = 1'b1;
        bus.link_out_data  = {6'd0, op_q};
      end
      S_TXL: begin
        bus.link_out_valid = 1'b1;
        bus.link_out_data  = tx_len_q[7:0];
      end
      S_TXH: begin
        bus.link_out_valid = 1'b1;
        bus.link_out_data  = tx_len_q[15:8];
      end
      S_RXL: begin
        bus.link_out_valid = 1'b1;
        bus.link_out_data  = rx_len_q[7:0];
      end
      S_RXH: begin
        bus.link_out_valid = 1'b1;
        bus.link_out_data  = rx_len_q[15:8];
      end
      S_PAYLOAD: begin
        bus.link_out_valid = bus.wr_valid;
        bus.link_out_data  = bus.wr_data;
        bus.wr_ready       = bus.link_out_ready;
      end
      S_RESP, S_VER: begin
        bus.rd_valid      = bus.link_in_valid;
        bus.rd_data       = bus.link_in_data;
        bus.link_in_ready = bus.rd_ready;
      end
      default: ;
    endcase
  end

  assign out_hs      = bus.link_out_valid && bus.link_out_ready;
  assign in_hs       = bus.link_in_valid && bus.link_in_ready;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_spi_bridge_host.sv
// tb/tb_spi_bridge_host.sv - table-driven transaction vectors plus reset and stray-byte sequences
module tb_spi_bridge_host;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_bridge_host_if bus ();

  spi_bridge_host #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] tx;
    logic [15:0] rx;
    int          hdr_n;
    logic [39:0] hdr;       // expected header bytes, first byte in the top octet
    int          pay_n;
    logic [7:0]  pay_base;
    logic [7:0]  pay_step;
    int          brg_n;     // bytes the bridge model offers back
    logic [7:0]  rsp_base;
    logic [7:0]  rsp_step;
    int          rd_n;
    bit          exp_done;
    bit          exp_to;
    bit          bp;
  } vec_t;

  vec_t vecs [9];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int out_n = 0, rd_n = 0, pay_i = 0, brg_i = 0;
    int done_n = 0, to_n = 0, last_hs = -1, done_it = -1, to_it = -1;
    int bad_out = 0, bad_rd = 0, unstable = 0, stall_run = 0, post = 0;
    int busy_at_to = 1;
    int budget;
    bit ended = 1'b0, prev_stall = 1'b0, force_rdy, hs_out, hs_in, hs_rd, hs_wr;
    logic [7:0] prev_data = 8'd0, exp_b;
    budget = 3 * (v.hdr_n + v.pay_n + v.brg_n) + 64;

    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_op     = v.op;
    bus.req_tx_len = v.tx;
    bus.req_rx_len = v.rx;
    #1;
    chk($sformatf("v%0d_req_ready", id), int'(bus.req_ready), 1);

    for (int it = 0; it < budget && !ended; it++) begin
      @(negedge clk);
      bus.req_valid      = 1'b0;
      force_rdy          = (stall_run >= 2) || !v.bp;
      bus.link_out_ready = force_rdy || ($urandom_range(0, 3) != 0);
      bus.rd_ready       = force_rdy || ($urandom_range(0, 3) != 0);
      bus.wr_valid       = (pay_i < v.pay_n);
      bus.wr_data        = v.pay_base + 8'(pay_i) * v.pay_step;
      bus.link_in_valid  = (out_n >= v.hdr_n + v.pay_n) && (brg_i < v.brg_n);
      bus.link_in_data   = v.rsp_base + 8'(brg_i) * v.rsp_step;
      #1;
      hs_out = bus.link_out_valid && bus.link_out_ready;
      hs_wr  = bus.wr_valid && bus.wr_ready;
      hs_in  = bus.link_in_valid && bus.link_in_ready;
      hs_rd  = bus.rd_valid && bus.rd_ready;
      if (it == 0)
        chk($sformatf("v%0d_first_out_valid", id), int'(bus.link_out_valid), int'(v.hdr_n > 0));
      if (prev_stall && !(bus.link_out_valid && bus.link_out_data == prev_data)) unstable++;
      prev_stall = bus.link_out_valid && !bus.link_out_ready;
      prev_data  = bus.link_out_data;
      if (hs_out) begin
        if (out_n < v.hdr_n) exp_b = v.hdr[39 - 8*out_n -: 8];
        else                 exp_b = v.pay_base + 8'(out_n - v.hdr_n) * v.pay_step;
        if (bus.link_out_data != exp_b) bad_out++;
        out_n++;
        last_hs = it;
      end
      if (hs_wr) pay_i++;
      if (hs_in) begin
        brg_i++;
        last_hs = it;
      end
      if (hs_rd) begin
        exp_b = v.rsp_base + 8'(rd_n) * v.rsp_step;
        if (bus.rd_data != exp_b) bad_rd++;
        rd_n++;
      end
      stall_run = (hs_out || hs_in) ? 0 : stall_run + 1;
      if (bus.done) begin
        done_n++;
        done_it = it;
      end
      if (bus.timeout) begin
        to_n++;
        to_it = it;
        busy_at_to = int'(bus.busy);
      end
      if (done_n > 0 || to_n > 0) begin
        post++;
        if (post > 3) ended = 1'b1;
      end
    end
    bus.wr_valid      = 1'b0;
    bus.link_in_valid = 1'b0;

    chk($sformatf("v%0d_finished", id), int'(ended), 1);
    chk($sformatf("v%0d_out_bytes", id), out_n, v.hdr_n + v.pay_n);
    chk($sformatf("v%0d_out_data_errs", id), bad_out, 0);
    chk($sformatf("v%0d_rd_bytes", id), rd_n, v.rd_n);
    chk($sformatf("v%0d_rd_data_errs", id), bad_rd, 0);
    chk($sformatf("v%0d_done_pulses", id), done_n, int'(v.exp_done));
    chk($sformatf("v%0d_timeout_pulses", id), to_n, int'(v.exp_to));
    chk($sformatf("v%0d_unstable_stalls", id), unstable, 0);
    if (v.exp_done) chk($sformatf("v%0d_done_latency", id), done_it - last_hs, 1);
    if (v.exp_to) begin
      chk($sformatf("v%0d_timeout_latency", id), to_it - last_hs, 17);
      chk($sformatf("v%0d_busy_at_timeout", id), busy_at_to, 0);
    end
    chk($sformatf("v%0d_busy_end", id), int'(bus.busy), 0);
  endtask

  initial begin
    bit leak;
    vecs[0] = '{2'd0, 16'd0, 16'd0, 1, 40'h00_00_00_00_00, 0, 8'h00, 8'h00,
                0, 8'h00, 8'h00, 0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{2'd1, 16'd3, 16'd2, 5, 40'h01_03_00_02_00, 3, 8'hA1, 8'h11,
                2, 8'h5A, 8'h11, 2, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{2'd2, 16'd0, 16'd0, 1, 40'h02_00_00_00_00, 0, 8'h00, 8'h00,
                1, 8'h02, 8'h00, 1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{2'd1, 16'd0, 16'd0, 5, 40'h01_00_00_00_00, 0, 8'h00, 8'h00,
                0, 8'h00, 8'h00, 0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{2'd3, 16'd7, 16'd7, 0, 40'h00_00_00_00_00, 0, 8'h00, 8'h00,
                0, 8'h00, 8'h00, 0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{2'd1, 16'd300, 16'd300, 5, 40'h01_2C_01_2C_01, 300, 8'h10, 8'h03,
                300, 8'h80, 8'h07, 300, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{2'd1, 16'd0, 16'd1, 5, 40'h01_00_00_01_00, 0, 8'h00, 8'h00,
                1, 8'hC7, 8'h00, 1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{2'd1, 16'd0, 16'd4, 5, 40'h01_00_00_04_00, 0, 8'h00, 8'h00,
                0, 8'h00, 8'h00, 0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{2'd1, 16'hFFFF, 16'd0, 5, 40'h01_FF_FF_00_00, 65535, 8'h00, 8'h01,
                0, 8'h00, 8'h00, 0, 1'b1, 1'b0, 1'b0};

    reset              = 1'b1;
    bus.req_valid      = 1'b0;
    bus.req_op         = 2'd0;
    bus.req_tx_len     = 16'd0;
    bus.req_rx_len     = 16'd0;
    bus.wr_valid       = 1'b0;
    bus.wr_data        = 8'd0;
    bus.rd_ready       = 1'b0;
    bus.link_out_ready = 1'b0;
    bus.link_in_valid  = 1'b0;
    bus.link_in_data   = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_timeout", int'(bus.timeout), 0);
    chk("rst_link_out_valid", int'(bus.link_out_valid), 0);
    chk("rst_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_wr_ready", int'(bus.wr_ready), 0);
    chk("rst_req_ready", int'(bus.req_ready), 1);

    // Stray bridge byte while idle is swallowed, never forwarded.
    @(negedge clk);
    bus.link_in_valid = 1'b1;
    bus.link_in_data  = 8'hEE;
    bus.rd_ready      = 1'b1;
    #1;
    chk("idle_link_in_ready", int'(bus.link_in_ready), 1);
    chk("idle_rd_valid", int'(bus.rd_valid), 0);
    @(negedge clk);
    bus.link_in_valid = 1'b0;
    #1;
    chk("idle_after_stray_busy", int'(bus.busy), 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset in the middle of a payload stream.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_op     = 2'd1;
    bus.req_tx_len = 16'd10;
    bus.req_rx_len = 16'd0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.req_valid      = 1'b0;
      bus.link_out_ready = 1'b1;
      bus.wr_valid       = 1'b1;
      bus.wr_data        = 8'h33;
    end
    #1;
    chk("midrst_busy_before", int'(bus.busy), 1);
    chk("midrst_wr_ready_before", int'(bus.wr_ready), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_link_out_valid", int'(bus.link_out_valid), 0);
    chk("midrst_done", int'(bus.done), 0);
    leak = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      leak |= bus.done || bus.timeout || bus.link_out_valid || bus.busy;
    end
    chk("midrst_quiet", int'(leak), 0);
    bus.wr_valid = 1'b0;
    run_vec(vecs[0], 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_bridge_host.md
SPI_BRIDGE_HOST -- requirements
Module: spi_bridge_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1200000, stall cycles without a link handshake before abort.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req_valid input 1 / req_ready output 1  request handshake.
REQ-005 SHALL have port req_op  input  2  0=boot, 1=transfer, 2=version, 3=reserved.
REQ-006 SHALL have ports req_tx_len, req_rx_len  input  16 each  transfer byte counts.
REQ-007 SHALL have ports wr_valid input 1 / wr_data input 8 / wr_ready output 1  payload stream to SPI.
REQ-008 SHALL have ports rd_valid output 1 / rd_data output 8 / rd_ready input 1  response stream from SPI or version.
REQ-009 SHALL have ports link_out_valid output 1 / link_out_data output 8 / link_out_ready input 1  bytes to bridge command input.
REQ-010 SHALL have ports link_in_valid input 1 / link_in_data input 8 / link_in_ready output 1  bytes from bridge output.
REQ-011 SHALL have ports busy output 1 / done output 1 / timeout output 1  status; done and timeout are one-cycle pulses.

Function
REQ-012 SHALL implement states IDLE, OP, TXL, TXH, RXL, RXH, PAYLOAD, RESP, VER.
REQ-013 IDLE: req_ready=1; on req_valid latch op, tx_len, rx_len; next state OP; op 3 SHALL instead pulse done next cycle and stay IDLE with no link bytes.
REQ-014 A byte transfers only on a cycle with valid && ready; every byte-emitting state SHALL hold link_out_valid=1 and data stable until link_out_ready.
REQ-015 OP emits op byte (0x00, 0x01, 0x02); after handshake: boot -> IDLE with done, transfer -> TXL, version -> VER.
REQ-016 TXL, TXH, RXL, RXH SHALL emit tx_len[7:0], tx_len[15:8], rx_len[7:0], rx_len[15:8] in that order.
REQ-017 After RXH: tx_len!=0 -> PAYLOAD; else rx_len!=0 -> RESP; else IDLE with done.
REQ-018 PAYLOAD: link_out_valid=wr_valid, link_out_data=wr_data, wr_ready=link_out_ready (combinational pass-through); wr_ready=0 in all other states.
REQ-019 PAYLOAD SHALL count with a 16-bit counter; on handshake of byte tx_len-1, go to RESP if rx_len!=0 else IDLE with done; counter cleared on state exit.
REQ-020 RESP: rd_valid=link_in_valid, rd_data=link_in_data, link_in_ready=rd_ready; after byte rx_len-1, go to IDLE with done.
REQ-021 VER: forward exactly one byte link_in->rd as in RESP, then IDLE with done.
REQ-022 IDLE SHALL hold link_in_ready=1 and discard stray link bytes (rd_valid=0); in OP..RXH and PAYLOAD link_in_ready=0.
REQ-023 Lengths are 16-bit unsigned; 0xFFFF SHALL transfer 65535 bytes with no counter wrap.
REQ-024 done SHALL be registered, asserted the cycle after the final handshake; busy = state!=IDLE.
REQ-025 Watchdog: counter SHALL increment each non-IDLE cycle without a link handshake, clear on any link handshake or IDLE.
REQ-026 On reaching TIMEOUT_CYCLES SHALL pulse timeout (no done), return to IDLE, drop partial progress.
REQ-027 Request accepted cycle N SHALL give first link_out_valid at N+1; new request accepted no earlier than cycle after done.

Reset
REQ-028 reset SHALL force IDLE, counters 0; busy, done, timeout, link_out_valid, rd_valid, wr_ready = 0; req_ready=1 next cycle.
REQ-029 reset mid-transfer SHALL abort immediately without done or timeout pulse and no further link bytes.

Verification
REQ-030 Transfer tx=3 rx=2, payload A1 B2 C3, bridge returns 5A 6B -> link_out 01 03 00 02 00 A1 B2 C3; rd 5A 6B; one done pulse.
REQ-031 Version op, bridge returns 02 -> link_out 02; rd 02; done.
REQ-032 Transfer tx=0 rx=0 -> link_out 01 00 00 00 00; no rd bytes; done after last header byte.
REQ-033 Random backpressure on link_out_ready and rd_ready, tx=300 rx=300 -> no lost/duplicated bytes, data stable while stalled.
REQ-034 TIMEOUT_CYCLES=16, rx=4, bridge silent -> timeout pulse at 16 stalled cycles, busy=0, no done.
REQ-035 reset asserted mid-PAYLOAD -> next cycle busy=0, link_out_valid=0, no done; following boot request emits 00.
